// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN grid engine: FSM states, edge-rule
// constants and the 3x3 window neighbour-index helper.
package cnn_pkg;

    localparam int WIDTH_DEF      = 9;
    localparam int BOUNDARY_ZERO  = 0;
    localparam int BOUNDARY_TORUS = 1;

    typedef enum logic [1:0] {IDLE, RUN, SWAP, FIN} state_t;

    typedef struct packed {
        logic       ok;
        logic [5:0] idx;
    } win_t;

    // Row-major index of neighbour (r+dr, c+dc); ok=0 when it falls off a zero-padded edge.
    function automatic win_t win_index(input int r, input int c, input int dr, input int dc,
                                       input int rows, input int cols, input int boundary);
        int   rr;
        int   cc;
        win_t w;
        rr   = r + dr;
        cc   = c + dc;
        w.ok = 1'b1;
        if (boundary == BOUNDARY_TORUS) begin
            if (rr < 0) rr = rr + rows;
            else if (rr >= rows) rr = rr - rows;
            if (cc < 0) cc = cc + cols;
            else if (cc >= cols) cc = cc - cols;
        end else if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) begin
            w.ok = 1'b0;
            rr   = 0;
            cc   = 0;
        end
        w.idx = 6'(rr * cols + cc);
        return w;
    endfunction

endpackage

// File: rtl/cnn_grid_engine_cell.sv
// Combinational CNN cell: sum of A*Y and B*U over the 3x3 window plus bias,
// truncated to 2*WIDTH bits without saturation.
module cnn_grid_engine_cell #(
    parameter int WIDTH = 9
) (
    input  logic [9*WIDTH-1:0]  a_flat,
    input  logic [9*WIDTH-1:0]  b_flat,
    input  logic [WIDTH-1:0]    i_bias,
    input  logic [9*WIDTH-1:0]  win_u,
    input  logic [18*WIDTH-1:0] win_y,
    output logic [2*WIDTH-1:0]  y
);

    localparam int YW    = 2 * WIDTH;
    localparam int ACC_W = 3 * WIDTH + 5;

    logic signed [ACC_W-1:0] acc;

    always_comb begin
        acc = ACC_W'($signed(i_bias));
        for (int i = 0; i < 9; i++) begin
            acc = acc
                + ACC_W'($signed(a_flat[i*WIDTH +: WIDTH])) * ACC_W'($signed(win_y[i*YW +: YW]))
                + ACC_W'($signed(b_flat[i*WIDTH +: WIDTH])) * ACC_W'($signed(win_u[i*WIDTH +: WIDTH]));
        end
        y = acc[YW-1:0];
    end

endmodule

// File: rtl/cnn_grid_engine.sv
// Time-multiplexed ROWSxCOLS CNN grid engine: one shared cell sweeps every grid
// position per iteration, with double-buffered Y for Jacobi-style updates.
module cnn_grid_engine
    import cnn_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int BOUNDARY = BOUNDARY_ZERO,
    parameter int ITER_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [9*WIDTH-1:0]            a_flat,
    input  logic [9*WIDTH-1:0]            b_flat,
    input  logic [WIDTH-1:0]              i_bias,
    input  logic                          u_wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]  u_wr_addr,
    input  logic [WIDTH-1:0]              u_wr_data,
    input  logic                          y_wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]  y_wr_addr,
    input  logic [2*WIDTH-1:0]            y_wr_data,
    input  logic [ITER_W-1:0]             iters,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic [$clog2(ROWS*COLS)-1:0]  rd_addr,
    output logic [2*WIDTH-1:0]            rd_data
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int YW = 2 * WIDTH;
    localparam logic [AW:0] LAST = (AW+1)'(N);

    state_t              state, next_state;
    logic [AW:0]         cnt;
    logic [3:0]          row, col;
    logic [ITER_W-1:0]   iter_left;
    logic                ptr;
    logic                issue;
    logic [WIDTH-1:0]    u_mem [N];
    logic [YW-1:0]       y_mem [2][N];

    logic [9*WIDTH-1:0]  win_u_d, win_u_p0;
    logic [9*YW-1:0]     win_y_d, win_y_p0;
    logic [AW-1:0]       addr_p0;
    logic                vld_p0;
    logic [YW-1:0]       cell_y;

    assign issue = (state == RUN) && (cnt < LAST);
    assign busy  = (state != IDLE);

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: if (start) next_state = (iters != '0) ? RUN : FIN;
            RUN:  if (cnt == LAST) next_state = SWAP;
            SWAP: next_state = (iter_left > ITER_W'(1)) ? RUN : FIN;
            FIN: begin
                next_state = IDLE;
                done       = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Stage p0 input: gather the 3x3 window around (row, col) from U and the committed Y buffer
    always_comb begin
        win_u_d = '0;
        win_y_d = '0;
        for (int i = 0; i < 9; i++) begin
            win_t w;
            w = win_index(int'(row), int'(col), i / 3 - 1, i % 3 - 1, ROWS, COLS, BOUNDARY);
            if (w.ok) begin
                win_u_d[i*WIDTH +: WIDTH] = u_mem[w.idx[AW-1:0]];
                win_y_d[i*YW +: YW]       = y_mem[ptr][w.idx[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            win_u_p0 <= win_u_d;
            win_y_p0 <= win_y_d;
            addr_p0  <= cnt[AW-1:0];
        end
    end

    // Stage p1: cell evaluates the registered window; result lands in the non-committed buffer
    cnn_grid_engine_cell #(.WIDTH(WIDTH)) u_cell (
        .a_flat (a_flat),
        .b_flat (b_flat),
        .i_bias (i_bias),
        .win_u  (win_u_p0),
        .win_y  (win_y_p0),
        .y      (cell_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
            iter_left <= '0;
            ptr       <= 1'b0;
            vld_p0    <= 1'b0;
            rd_data   <= '0;
            for (int k = 0; k < N; k++) begin
                u_mem[k]    <= '0;
                y_mem[0][k] <= '0;
                y_mem[1][k] <= '0;
            end
        end else begin
            state   <= next_state;
            vld_p0  <= issue;
            rd_data <= (int'(rd_addr) < N) ? y_mem[ptr][rd_addr] : '0;
            case (state)
                IDLE: begin
                    if (u_wr_en && int'(u_wr_addr) < N) u_mem[u_wr_addr] <= u_wr_data;
                    if (y_wr_en && int'(y_wr_addr) < N) y_mem[ptr][y_wr_addr] <= y_wr_data;
                    if (start) iter_left <= iters;
                    cnt <= '0;
                    row <= '0;
                    col <= '0;
                end
                RUN: if (issue) begin
                    cnt <= cnt + 1'b1;
                    if (int'(col) == COLS - 1) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                SWAP: begin
                    // Pointer toggle commits the finished iteration
                    ptr       <= ~ptr;
                    iter_left <= iter_left - 1'b1;
                    cnt       <= '0;
                    row       <= '0;
                    col       <= '0;
                end
                default: ;
            endcase
            if (vld_p0) y_mem[~ptr][addr_p0] <= cell_y;
        end
    end

endmodule
